reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Unified, out-of-order reservation station for the integer issue stage, with zero-latency wakeup.
- Accepts up to ISSUE_W renamed micro-ops per cycle and captures operands from the CDB.
- Every cycle, combinationally selects up to ISSUE_W ready ops, oldest first, and sends them to the execution units.
- An op whose operands are ready at allocation, or become ready via the same-cycle CDB, issues in that same cycle.

Parameters:
- RS_ENTRIES, 16, number of storage entries.
- ISSUE_W, 2, number of allocation ports and number of issue ports.
- CDB_W, 2, number of CDB broadcast lanes.
- PHYS_W, 6, physical register tag width.
- Fixed widths (not parameters): value 64, opcode 8, ROB tag 6.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- alloc_en  in  ISSUE_W  per-port allocate request
- alloc_dst_tag  in  ISSUE_W x PHYS_W  destination physical tag
- alloc_src1_tag / alloc_src2_tag  in  ISSUE_W x PHYS_W  source tags
- alloc_src1_val / alloc_src2_val  in  ISSUE_W x 64  source values; meaningful only when the matching ready bit is 1
- alloc_src1_ready / alloc_src2_ready  in  ISSUE_W  source-available flags
- alloc_op  in  ISSUE_W x 8  opcode
- alloc_rob_tag  in  ISSUE_W x 6  ROB index
- cdb_valid  in  CDB_W  broadcast valid
- cdb_tag  in  CDB_W x PHYS_W  produced tag
- cdb_value  in  CDB_W x 64  produced value
- issue_valid  out  ISSUE_W  issue slot valid
- issue_op  out  ISSUE_W x 8  opcode
- issue_dst_tag  out  ISSUE_W x PHYS_W  destination tag
- issue_src1_val / issue_src2_val  out  ISSUE_W x 64  operand values
- issue_rob_tag  out  ISSUE_W x 6  ROB index

Behaviour:
- Storage: array rs_mem[RS_ENTRIES] (hierarchically visible to verification). Fields per entry:
  - valid, opcode, dst_tag, rob_tag
  - src1_tag, src1_val, src1_ready
  - src2_tag, src2_val, src2_ready
  - age (8-bit)
- Reset (async): all entries have valid=0, all other fields 0. While reset is high, all issue outputs are 0 and allocations are ignored.
- Effective readiness of a source: stored ready bit, OR a current-cycle CDB lane with cdb_valid=1 and cdb_tag equal to the source tag.
  - Effective value is the CDB value when the stored ready bit is 0 and a lane matches; otherwise the stored value.
  - If several lanes match, the lowest lane index wins.
- Candidate set:
  - every valid stored entry with both sources effectively ready;
  - every enabled allocation port with both sources effectively ready (bypass path).
- Selection order, oldest first:
  - stored entries by largest age, ties broken by lowest index;
  - then allocation port 0, then port 1.
  - The first ISSUE_W candidates fill issue slots 0..ISSUE_W-1 in order.
- Issue outputs are purely combinational: same-cycle allocation-to-issue and CDB-to-issue latency is zero.
  - Unused slots drive issue_valid=0 and all other fields 0.
  - There is no downstream stall; an issue is always accepted.
- Clock edge, for a stored entry:
  - if issued, valid is cleared;
  - otherwise any CDB match sets that source's ready bit and captures the value, and age increments, saturating at 255.
- Clock edge, for an allocation:
  - if issued via bypass, it is not written.
  - Otherwise it is written into a free entry with age 0 and current-cycle CDB matches folded in.
  - Port 0 takes the lowest-index free entry, port 1 the next lowest. Free means valid=0 at the start of the cycle.
- Full: if no free entry exists for a non-bypassed allocation, that allocation is dropped. Upstream guarantees space; no stall output.
- A source with ready=1 at allocation never snoops the CDB.
- An entry whose operands are ready issues in the cycle its wakeup broadcast appears, not one cycle later.

Test Plan:
- Same-cycle bypass:
  - Stimulus: port0 ADD(op 01) dst p10, src p1=5 ready, p2=3 ready, ROB0; port1 SUB(op 02) dst p11, src1 p10 not ready, src2 p3=7 ready, ROB1.
  - Response: same cycle issue_valid=01, slot0 = op01, vals 5/3, dst p10, ROB0. After the edge only the SUB is stored, with src1_ready=0.
- CDB wakeup:
  - Stimulus: next cycle, CDB lane0 p10=8; port0 AND(op 03) dst p12, src 2/6 both ready, ROB2.
  - Response: issue_valid=11; slot0 = SUB, vals 8/7, dst p11; slot1 = AND, vals 2/6, dst p12.
- Drain: after that edge, all rs_mem valid bits are 0 and issue_valid=00, even with CDB lanes still asserting p11 and p12.
- Age ordering:
  - Stimulus: fill 3 entries blocked on p20 in successive cycles, then broadcast p20.
  - Response: the two oldest issue in slots 0 and 1; the third issues the next cycle.
- Full:
  - Stimulus: fill 16 blocked entries, then allocate one more blocked op.
  - Response: it is dropped and the entry count stays 16. A ready op in the same situation still issues via bypass.
- Async reset:
  - Stimulus: assert reset mid-cycle with entries valid.
  - Response: immediately all entries are invalid and issue_valid=0, without waiting for a clock edge.

Source files
------------

// File: rtl/reservation_station.sv
// Unified integer reservation station: CDB operand capture, oldest-first select of up to
// ISSUE_W ready ops per cycle, with same-cycle allocation and wakeup bypass to issue.
module reservation_station #(
    parameter int RS_ENTRIES = 16,
    parameter int ISSUE_W    = 2,
    parameter int CDB_W      = 2,
    parameter int PHYS_W     = 6
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ISSUE_W-1:0]               alloc_en,
    input  logic [ISSUE_W-1:0][PHYS_W-1:0]   alloc_dst_tag,
    input  logic [ISSUE_W-1:0][PHYS_W-1:0]   alloc_src1_tag,
    input  logic [ISSUE_W-1:0][PHYS_W-1:0]   alloc_src2_tag,
    input  logic [ISSUE_W-1:0][63:0]         alloc_src1_val,
    input  logic [ISSUE_W-1:0][63:0]         alloc_src2_val,
    input  logic [ISSUE_W-1:0]               alloc_src1_ready,
    input  logic [ISSUE_W-1:0]               alloc_src2_ready,
    input  logic [ISSUE_W-1:0][7:0]          alloc_op,
    input  logic [ISSUE_W-1:0][5:0]          alloc_rob_tag,
    input  logic [CDB_W-1:0]                 cdb_valid,
    input  logic [CDB_W-1:0][PHYS_W-1:0]     cdb_tag,
    input  logic [CDB_W-1:0][63:0]           cdb_value,
    output logic [ISSUE_W-1:0]               issue_valid,
    output logic [ISSUE_W-1:0][7:0]          issue_op,
    output logic [ISSUE_W-1:0][PHYS_W-1:0]   issue_dst_tag,
    output logic [ISSUE_W-1:0][63:0]         issue_src1_val,
    output logic [ISSUE_W-1:0][63:0]         issue_src2_val,
    output logic [ISSUE_W-1:0][5:0]          issue_rob_tag
);

    localparam int IDX_W = $clog2(RS_ENTRIES);

    typedef struct packed {
        logic              valid;
        logic [7:0]        opcode;
        logic [PHYS_W-1:0] dst_tag;
        logic [5:0]        rob_tag;
        logic [PHYS_W-1:0] src1_tag;
        logic [63:0]       src1_val;
        logic              src1_ready;
        logic [PHYS_W-1:0] src2_tag;
        logic [63:0]       src2_val;
        logic              src2_ready;
        logic [7:0]        age;
    } rs_entry_t;

    rs_entry_t rs_mem [RS_ENTRIES];

    logic [RS_ENTRIES-1:0] w_ent_s1_rdy, w_ent_s2_rdy, w_ent_cand, w_ent_issued;
    logic [63:0]           w_ent_s1_val [RS_ENTRIES];
    logic [63:0]           w_ent_s2_val [RS_ENTRIES];
    logic [ISSUE_W-1:0]    w_al_s1_rdy, w_al_s2_rdy, w_alloc_cand, w_alloc_issued, w_alloc_wr;
    logic [63:0]           w_al_s1_val [ISSUE_W];
    logic [63:0]           w_al_s2_val [ISSUE_W];
    logic [IDX_W-1:0]      w_alloc_idx [ISSUE_W];
    rs_entry_t             w_new_ent   [ISSUE_W];

    // {effective ready, effective value}; a source already ready never snoops, lowest lane wins.
    function automatic logic [64:0] snoop(input logic [PHYS_W-1:0] tag, input logic rdy,
                                          input logic [63:0] val);
        logic        hit;
        logic [63:0] v;
        hit = 1'b0;
        v   = val;
        if (!rdy) begin
            for (int l = CDB_W - 1; l >= 0; l--) begin
                if (cdb_valid[l] && cdb_tag[l] == tag) begin
                    hit = 1'b1;
                    v   = cdb_value[l];
                end
            end
        end
        return {rdy | hit, v};
    endfunction

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            {w_ent_s1_rdy[i], w_ent_s1_val[i]} = snoop(rs_mem[i].src1_tag, rs_mem[i].src1_ready,
                                                       rs_mem[i].src1_val);
            {w_ent_s2_rdy[i], w_ent_s2_val[i]} = snoop(rs_mem[i].src2_tag, rs_mem[i].src2_ready,
                                                       rs_mem[i].src2_val);
            w_ent_cand[i] = rs_mem[i].valid & w_ent_s1_rdy[i] & w_ent_s2_rdy[i];
        end
        for (int p = 0; p < ISSUE_W; p++) begin
            {w_al_s1_rdy[p], w_al_s1_val[p]} = snoop(alloc_src1_tag[p], alloc_src1_ready[p],
                                                     alloc_src1_val[p]);
            {w_al_s2_rdy[p], w_al_s2_val[p]} = snoop(alloc_src2_tag[p], alloc_src2_ready[p],
                                                     alloc_src2_val[p]);
            w_alloc_cand[p] = alloc_en[p] & ~reset & w_al_s1_rdy[p] & w_al_s2_rdy[p];
        end
    end

    // Each slot takes the oldest remaining stored candidate; bypass ports fill what is left.
    always_comb begin : select_logic
        logic             found;
        logic [7:0]       best_age;
        logic [IDX_W-1:0] best_idx;
        w_ent_issued   = '0;
        w_alloc_issued = '0;
        issue_valid    = '0;
        issue_op       = '0;
        issue_dst_tag  = '0;
        issue_src1_val = '0;
        issue_src2_val = '0;
        issue_rob_tag  = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            found    = 1'b0;
            best_age = '0;
            best_idx = '0;
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (w_ent_cand[i] && !w_ent_issued[i] && (!found || rs_mem[i].age > best_age)) begin
                    found    = 1'b1;
                    best_age = rs_mem[i].age;
                    best_idx = IDX_W'(i);
                end
            end
            if (found) begin
                w_ent_issued[best_idx] = 1'b1;
                issue_valid[k]         = 1'b1;
                issue_op[k]            = rs_mem[best_idx].opcode;
                issue_dst_tag[k]       = rs_mem[best_idx].dst_tag;
                issue_rob_tag[k]       = rs_mem[best_idx].rob_tag;
                issue_src1_val[k]      = w_ent_s1_val[best_idx];
                issue_src2_val[k]      = w_ent_s2_val[best_idx];
            end else begin
                for (int p = 0; p < ISSUE_W; p++) begin
                    if (!found && w_alloc_cand[p] && !w_alloc_issued[p]) begin
                        found             = 1'b1;
                        w_alloc_issued[p] = 1'b1;
                        issue_valid[k]    = 1'b1;
                        issue_op[k]       = alloc_op[p];
                        issue_dst_tag[k]  = alloc_dst_tag[p];
                        issue_rob_tag[k]  = alloc_rob_tag[p];
                        issue_src1_val[k] = w_al_s1_val[p];
                        issue_src2_val[k] = w_al_s2_val[p];
                    end
                end
            end
        end
    end

    // Non-bypassed allocations claim free entries lowest index first, in port order.
    always_comb begin : place_logic
        logic [RS_ENTRIES-1:0] claimed;
        logic                  found;
        claimed    = '0;
        w_alloc_wr = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            found          = 1'b0;
            w_alloc_idx[p] = '0;
            if (alloc_en[p] && !w_alloc_issued[p]) begin
                for (int i = 0; i < RS_ENTRIES; i++) begin
                    if (!found && !rs_mem[i].valid && !claimed[i]) begin
                        found          = 1'b1;
                        claimed[i]     = 1'b1;
                        w_alloc_idx[p] = IDX_W'(i);
                    end
                end
            end
            w_alloc_wr[p]            = found;
            w_new_ent[p]             = '0;
            w_new_ent[p].valid       = 1'b1;
            w_new_ent[p].opcode      = alloc_op[p];
            w_new_ent[p].dst_tag     = alloc_dst_tag[p];
            w_new_ent[p].rob_tag     = alloc_rob_tag[p];
            w_new_ent[p].src1_tag    = alloc_src1_tag[p];
            w_new_ent[p].src1_val    = w_al_s1_val[p];
            w_new_ent[p].src1_ready  = w_al_s1_rdy[p];
            w_new_ent[p].src2_tag    = alloc_src2_tag[p];
            w_new_ent[p].src2_val    = w_al_s2_val[p];
            w_new_ent[p].src2_ready  = w_al_s2_rdy[p];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                rs_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) begin
                if (rs_mem[i].valid) begin
                    if (w_ent_issued[i]) begin
                        rs_mem[i].valid <= 1'b0;
                    end else begin
                        rs_mem[i].src1_ready <= w_ent_s1_rdy[i];
                        rs_mem[i].src1_val   <= w_ent_s1_val[i];
                        rs_mem[i].src2_ready <= w_ent_s2_rdy[i];
                        rs_mem[i].src2_val   <= w_ent_s2_val[i];
                        if (rs_mem[i].age != 8'hFF) begin
                            rs_mem[i].age <= rs_mem[i].age + 8'd1;
                        end
                    end
                end
            end
            for (int p = 0; p < ISSUE_W; p++) begin
                if (w_alloc_wr[p]) begin
                    rs_mem[w_alloc_idx[p]] <= w_new_ent[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: bypass, CDB wakeup, drain, age order, full, async reset.
module tb_reservation_station;

    localparam int RS_ENTRIES = 16;
    localparam int ISSUE_W    = 2;
    localparam int CDB_W      = 2;
    localparam int PHYS_W     = 6;

    logic                           clk;
    logic                           reset;
    logic [ISSUE_W-1:0]             alloc_en;
    logic [ISSUE_W-1:0][PHYS_W-1:0] alloc_dst_tag, alloc_src1_tag, alloc_src2_tag;
    logic [ISSUE_W-1:0][63:0]       alloc_src1_val, alloc_src2_val;
    logic [ISSUE_W-1:0]             alloc_src1_ready, alloc_src2_ready;
    logic [ISSUE_W-1:0][7:0]        alloc_op;
    logic [ISSUE_W-1:0][5:0]        alloc_rob_tag;
    logic [CDB_W-1:0]               cdb_valid;
    logic [CDB_W-1:0][PHYS_W-1:0]   cdb_tag;
    logic [CDB_W-1:0][63:0]         cdb_value;
    logic [ISSUE_W-1:0]             issue_valid;
    logic [ISSUE_W-1:0][7:0]        issue_op;
    logic [ISSUE_W-1:0][PHYS_W-1:0] issue_dst_tag;
    logic [ISSUE_W-1:0][63:0]       issue_src1_val, issue_src2_val;
    logic [ISSUE_W-1:0][5:0]        issue_rob_tag;

    int n_checks;
    int n_fail;

    reservation_station #(
        .RS_ENTRIES(RS_ENTRIES), .ISSUE_W(ISSUE_W), .CDB_W(CDB_W), .PHYS_W(PHYS_W)
    ) dut (
        .clk(clk), .reset(reset),
        .alloc_en(alloc_en), .alloc_dst_tag(alloc_dst_tag),
        .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
        .alloc_src1_val(alloc_src1_val), .alloc_src2_val(alloc_src2_val),
        .alloc_src1_ready(alloc_src1_ready), .alloc_src2_ready(alloc_src2_ready),
        .alloc_op(alloc_op), .alloc_rob_tag(alloc_rob_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_op(issue_op), .issue_dst_tag(issue_dst_tag),
        .issue_src1_val(issue_src1_val), .issue_src2_val(issue_src2_val),
        .issue_rob_tag(issue_rob_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        alloc_en         = '0;
        alloc_dst_tag    = '0;
        alloc_src1_tag   = '0;
        alloc_src2_tag   = '0;
        alloc_src1_val   = '0;
        alloc_src2_val   = '0;
        alloc_src1_ready = '0;
        alloc_src2_ready = '0;
        alloc_op         = '0;
        alloc_rob_tag    = '0;
        cdb_valid        = '0;
        cdb_tag          = '0;
        cdb_value        = '0;
    endtask

    task automatic drive_alloc(input int p, input logic [7:0] op, input logic [5:0] dst,
                               input logic [5:0] rob,
                               input logic [5:0] t1, input logic [63:0] v1, input logic r1,
                               input logic [5:0] t2, input logic [63:0] v2, input logic r2);
        alloc_en[p]         = 1'b1;
        alloc_op[p]         = op;
        alloc_dst_tag[p]    = dst;
        alloc_rob_tag[p]    = rob;
        alloc_src1_tag[p]   = t1;
        alloc_src1_val[p]   = v1;
        alloc_src1_ready[p] = r1;
        alloc_src2_tag[p]   = t2;
        alloc_src2_val[p]   = v2;
        alloc_src2_ready[p] = r2;
    endtask

    task automatic drive_cdb(input int l, input logic [5:0] tag, input logic [63:0] val);
        cdb_valid[l] = 1'b1;
        cdb_tag[l]   = tag;
        cdb_value[l] = val;
    endtask

    task automatic check_slot(input string tag, input int k, input logic [7:0] op,
                              input logic [5:0] dst, input logic [5:0] rob,
                              input logic [63:0] v1, input logic [63:0] v2);
        check_eq({tag, "_op"},  issue_op[k],       op);
        check_eq({tag, "_dst"}, issue_dst_tag[k],  dst);
        check_eq({tag, "_rob"}, issue_rob_tag[k],  rob);
        check_eq({tag, "_v1"},  issue_src1_val[k], v1);
        check_eq({tag, "_v2"},  issue_src2_val[k], v2);
    endtask

    function automatic int count_valid();
        int n = 0;
        for (int i = 0; i < RS_ENTRIES; i++) if (dut.rs_mem[i].valid) n++;
        return n;
    endfunction

    function automatic int has_op(input logic [7:0] op);
        int n = 0;
        for (int i = 0; i < RS_ENTRIES; i++)
            if (dut.rs_mem[i].valid && dut.rs_mem[i].opcode == op) n++;
        return n;
    endfunction

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_issue_valid", issue_valid, 2'b00);
        check_eq("rst_count", count_valid(), 0);
        reset = 1'b0;

        // Same-cycle bypass: ADD issues at once, SUB waits on p10
        drive_alloc(0, 8'h01, 6'd10, 6'd0, 6'd1, 64'd5, 1'b1, 6'd2, 64'd3, 1'b1);
        drive_alloc(1, 8'h02, 6'd11, 6'd1, 6'd10, 64'd0, 1'b0, 6'd3, 64'd7, 1'b1);
        sample();
        check_eq("byp_valid", issue_valid, 2'b01);
        check_slot("byp_s0", 0, 8'h01, 6'd10, 6'd0, 64'd5, 64'd3);
        check_eq("byp_s1_op", issue_op[1], 8'h00);
        advance();
        clear_inputs();
        check_eq("byp_count", count_valid(), 1);
        check_eq("byp_sub_stored", has_op(8'h02), 1);
        for (int i = 0; i < RS_ENTRIES; i++)
            if (dut.rs_mem[i].valid) check_eq("byp_sub_s1rdy", dut.rs_mem[i].src1_ready, 1'b0);

        // CDB wakeup: stored SUB (older) in slot 0, bypassed AND in slot 1
        drive_cdb(0, 6'd10, 64'd8);
        drive_alloc(0, 8'h03, 6'd12, 6'd2, 6'd4, 64'd2, 1'b1, 6'd5, 64'd6, 1'b1);
        sample();
        check_eq("wake_valid", issue_valid, 2'b11);
        check_slot("wake_s0", 0, 8'h02, 6'd11, 6'd1, 64'd8, 64'd7);
        check_slot("wake_s1", 1, 8'h03, 6'd12, 6'd2, 64'd2, 64'd6);
        advance();
        clear_inputs();

        // Drain: nothing left even with stale tags on the CDB
        drive_cdb(0, 6'd11, 64'd99);
        drive_cdb(1, 6'd12, 64'd77);
        sample();
        check_eq("drain_count", count_valid(), 0);
        check_eq("drain_valid", issue_valid, 2'b00);
        advance();
        clear_inputs();

        // Age ordering: three ops blocked on p20, allocated in successive cycles
        drive_alloc(0, 8'h10, 6'd21, 6'd3, 6'd20, 64'd0, 1'b0, 6'd0, 64'd1, 1'b1);
        advance();
        clear_inputs();
        drive_alloc(0, 8'h11, 6'd22, 6'd4, 6'd20, 64'd0, 1'b0, 6'd0, 64'd2, 1'b1);
        advance();
        clear_inputs();
        drive_alloc(0, 8'h12, 6'd23, 6'd5, 6'd20, 64'd0, 1'b0, 6'd0, 64'd3, 1'b1);
        sample();
        check_eq("age_blocked_valid", issue_valid, 2'b00);
        advance();
        clear_inputs();
        check_eq("age_count", count_valid(), 3);
        // both lanes carry p20; lane 0 must win
        drive_cdb(0, 6'd20, 64'd100);
        drive_cdb(1, 6'd20, 64'd200);
        sample();
        check_eq("age_valid", issue_valid, 2'b11);
        check_slot("age_s0", 0, 8'h10, 6'd21, 6'd3, 64'd100, 64'd1);
        check_slot("age_s1", 1, 8'h11, 6'd22, 6'd4, 64'd100, 64'd2);
        advance();
        clear_inputs();
        sample();
        check_eq("age_next_valid", issue_valid, 2'b01);
        check_slot("age_next_s0", 0, 8'h12, 6'd23, 6'd5, 64'd100, 64'd3);
        advance();
        check_eq("age_empty", count_valid(), 0);

        // Full: sixteen ops blocked on p30
        for (int c = 0; c < 8; c++) begin
            clear_inputs();
            drive_alloc(0, 8'(8'h20 + 2 * c), 6'd40, 6'(2 * c), 6'd30, 64'd0, 1'b0, 6'd0, 64'd1, 1'b1);
            drive_alloc(1, 8'(8'h21 + 2 * c), 6'd41, 6'(2 * c + 1), 6'd30, 64'd0, 1'b0, 6'd0, 64'd1, 1'b1);
            advance();
        end
        clear_inputs();
        check_eq("full_count", count_valid(), 16);
        drive_alloc(0, 8'h66, 6'd42, 6'd20, 6'd30, 64'd0, 1'b0, 6'd0, 64'd1, 1'b1);
        sample();
        check_eq("full_drop_valid", issue_valid, 2'b00);
        advance();
        clear_inputs();
        check_eq("full_drop_count", count_valid(), 16);
        check_eq("full_drop_absent", has_op(8'h66), 0);
        drive_alloc(0, 8'h55, 6'd43, 6'd21, 6'd1, 64'd9, 1'b1, 6'd2, 64'd4, 1'b1);
        sample();
        check_eq("full_byp_valid", issue_valid, 2'b01);
        check_slot("full_byp_s0", 0, 8'h55, 6'd43, 6'd21, 64'd9, 64'd4);
        advance();
        clear_inputs();
        check_eq("full_byp_count", count_valid(), 16);

        // Async reset mid-cycle: entries and issue outputs clear without an edge
        drive_alloc(0, 8'h77, 6'd44, 6'd22, 6'd1, 64'd1, 1'b1, 6'd2, 64'd2, 1'b1);
        sample();
        check_eq("arst_pre_valid", issue_valid, 2'b01);
        #2;
        reset = 1'b1;
        #1;
        check_eq("arst_count", count_valid(), 0);
        check_eq("arst_valid", issue_valid, 2'b00);
        advance();
        check_eq("arst_hold_count", count_valid(), 0);
        reset = 1'b0;
        sample();
        check_eq("arst_after_valid", issue_valid, 2'b01);
        check_eq("arst_after_op", issue_op[0], 8'h77);
        advance();
        clear_inputs();
        check_eq("arst_after_count", count_valid(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
